// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters with registered position, blank and sync outputs.
// Define VGA_FRAME_COUNT_EN to build the completed-frame counter; otherwise frame_count is tied to 0.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_TOTAL   = 800,
  parameter int V_VISIBLE = 480,
  parameter int V_TOTAL   = 525
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        restart,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  // Sync pulses sit after a fixed front porch; back porch takes whatever remains of the total.
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + 16);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + 16 + 96 - 1);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + 10);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + 10 + 2 - 1);

  logic [9:0] hc_q, hc_d, vc_q, vc_d;
  logic [9:0] drawx_q, drawy_q;
  logic       blank_q, blank_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic       h_wrap;

  always_comb begin
    h_wrap = (hc_q == H_LAST);
    hc_d   = h_wrap ? 10'd0 : hc_q + 10'd1;
    vc_d   = vc_q;
    if (h_wrap) begin
      vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
    end
    if (restart) begin
      hc_d = 10'd0;
      vc_d = 10'd0;
    end
  end

  // Outputs are decoded from the pre-advance counter value so they all describe one position.
  always_comb begin
    blank_d = (hc_q < H_VIS) && (vc_q < V_VIS);
    hs_d    = !((hc_q >= HS_START) && (hc_q <= HS_END));
    vs_d    = !((vc_q >= VS_START) && (vc_q <= VS_END));
    fs_d    = (hc_q == 10'd0) && (vc_q == 10'd0);
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc_q    <= 10'd0;
      vc_q    <= 10'd0;
      drawx_q <= 10'd0;
      drawy_q <= 10'd0;
      blank_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      drawx_q <= hc_q;
      drawy_q <= vc_q;
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
    end
  end

  assign DrawX       = drawx_q;
  assign DrawY       = drawy_q;
  assign blank       = blank_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign frame_start = fs_q;

`ifdef VGA_FRAME_COUNT_EN
  // Only the natural end-of-frame wrap counts; a restart landing on it still counts once.
  logic [15:0] fc_q, fc_d;
  logic        frame_wrap;

  always_comb begin
    frame_wrap = h_wrap && (vc_q == V_LAST);
    fc_d       = frame_wrap ? fc_q + 16'd1 : fc_q;
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      fc_q <= 16'd0;
    end else begin
      fc_q <= fc_d;
    end
  end

  assign frame_count = fc_q;
`else
  assign frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full 800-clock lines with a short frame (2 visible + 45 blank lines).
module tb_vga_timing_gen;

`ifdef VGA_FRAME_COUNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  localparam int HT = 800;
  localparam int VT = 47;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        restart = 1'b0;
  logic [9:0]  DrawX, DrawY;
  logic        blank, hs, vs, frame_start;
  logic [15:0] frame_count;
  logic [23:0] obs;
  logic [15:0] exp_fc;

  int n_checks = 0;
  int n_fail   = 0;

  vga_timing_gen #(
    .H_VISIBLE(640), .H_TOTAL(HT), .V_VISIBLE(2), .V_TOTAL(VT)
  ) dut (
    .vga_clk(clk), .reset(reset), .restart(restart),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank), .hs(hs), .vs(vs),
    .frame_start(frame_start), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  assign obs = {DrawX, DrawY, blank, hs, vs, frame_start};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [23:0] e;
    reset = 1'b1; restart = 1'b0;
    repeat (2) @(negedge clk);
    e = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, e); end
    n_checks++;
    if (frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_fc: got %0d expected 0", frame_count); end
    reset = 1'b0;
    tick();
    e = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL first_edge: got %h expected %h", obs, e); end
    n_checks++;
    if (frame_count !== 16'd0) begin n_fail++; $display("FAIL first_edge_fc: got %0d expected 0", frame_count); end
  endtask

  task automatic test_line();
    int seq_err = 0, y_err = 0, blank_n = 0, blank_last = -1;
    int hs_n = 0, hs_first = -1, hs_last = -1;
    for (int i = 0; i < HT; i++) begin
      if (DrawX !== 10'(i)) seq_err++;
      if (DrawY !== 10'd0) y_err++;
      if (blank === 1'b1) begin blank_n++; blank_last = int'(DrawX); end
      if (hs === 1'b0) begin
        if (hs_first < 0) hs_first = int'(DrawX);
        hs_last = int'(DrawX);
        hs_n++;
      end
      tick();
    end
    n_checks++;
    if (seq_err != 0) begin n_fail++; $display("FAIL line_xseq: got %0d errors expected 0", seq_err); end
    n_checks++;
    if (y_err != 0) begin n_fail++; $display("FAIL line_y: got %0d errors expected 0", y_err); end
    n_checks++;
    if (blank_n != 640) begin n_fail++; $display("FAIL line_blank_n: got %0d expected 640", blank_n); end
    n_checks++;
    if (blank_last != 639) begin n_fail++; $display("FAIL line_blank_last: got %0d expected 639", blank_last); end
    n_checks++;
    if (hs_n != 96) begin n_fail++; $display("FAIL line_hs_n: got %0d expected 96", hs_n); end
    n_checks++;
    if (hs_first != 656) begin n_fail++; $display("FAIL line_hs_first: got %0d expected 656", hs_first); end
    n_checks++;
    if (hs_last != 751) begin n_fail++; $display("FAIL line_hs_last: got %0d expected 751", hs_last); end
  endtask

  // Starts at (0,1); walks to the last pixel of the frame and across the natural wrap.
  task automatic test_frame();
    int n = 0, vs_n = 0, vs_min = 1023, vs_max = -1, fs_n = 0, blank_n = 0;
    logic [15:0] prev_fc;
    logic [23:0] e;
    prev_fc = frame_count;
    while (!(DrawX === 10'd799 && DrawY === 10'(VT - 1)) && n < 40000) begin
      if (vs === 1'b0) begin
        vs_n++;
        if (int'(DrawY) < vs_min) vs_min = int'(DrawY);
        if (int'(DrawY) > vs_max) vs_max = int'(DrawY);
      end
      if (frame_start === 1'b1) fs_n++;
      if (blank === 1'b1) blank_n++;
      prev_fc = frame_count;
      tick();
      n++;
    end
    n_checks++;
    if (n != 36799) begin n_fail++; $display("FAIL frame_len: got %0d expected 36799", n); end
    n_checks++;
    if (vs_n != 1600) begin n_fail++; $display("FAIL frame_vs_n: got %0d expected 1600", vs_n); end
    n_checks++;
    if (vs_min != 12 || vs_max != 13) begin
      n_fail++; $display("FAIL frame_vs_lines: got %0d..%0d expected 12..13", vs_min, vs_max);
    end
    n_checks++;
    if (fs_n != 0) begin n_fail++; $display("FAIL frame_fs_extra: got %0d expected 0", fs_n); end
    n_checks++;
    if (blank_n != 640) begin n_fail++; $display("FAIL frame_blank_n: got %0d expected 640", blank_n); end
    n_checks++;
    if (prev_fc !== 16'd0) begin n_fail++; $display("FAIL frame_fc_before: got %0d expected 0", prev_fc); end
    exp_fc = FC_EN ? 16'd1 : 16'd0;
    n_checks++;
    if (frame_count !== exp_fc) begin n_fail++; $display("FAIL frame_fc_wrap: got %0d expected %0d", frame_count, exp_fc); end
    tick();
    e = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL frame_next_origin: got %h expected %h", obs, e); end
  endtask

  task automatic test_restart_mid();
    int n = 0;
    logic [23:0] e;
    while (!(DrawX === 10'd300 && DrawY === 10'd1) && n < 2000) begin tick(); n++; end
    n_checks++;
    if (n >= 2000) begin n_fail++; $display("FAIL rst_mid_reach: got timeout expected (300,1)"); end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tick();
    e = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL restart_origin: got %h expected %h", obs, e); end
    n_checks++;
    if (frame_count !== exp_fc) begin n_fail++; $display("FAIL restart_fc: got %0d expected %0d", frame_count, exp_fc); end
    tick();
    e = {10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL restart_resume: got %h expected %h", obs, e); end
  endtask

  task automatic test_restart_hold();
    logic [23:0] e;
    e = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    restart = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k >= 1) begin
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL hold_origin_%0d: got %h expected %h", k, obs, e); end
      end
    end
    restart = 1'b0;
    tick();
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL hold_release: got %h expected %h", obs, e); end
    tick();
    e = {10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL hold_resume: got %h expected %h", obs, e); end
    n_checks++;
    if (frame_count !== exp_fc) begin n_fail++; $display("FAIL hold_fc: got %0d expected %0d", frame_count, exp_fc); end
  endtask

  // Restart requested while the counters sit on the last pixel of the frame.
  task automatic test_back_to_back();
    int n = 0;
    logic [23:0] e;
    while (!(DrawX === 10'd798 && DrawY === 10'(VT - 1)) && n < 40000) begin tick(); n++; end
    n_checks++;
    if (n != 37597) begin n_fail++; $display("FAIL b2b_len: got %0d expected 37597", n); end
    n_checks++;
    if (frame_count !== exp_fc) begin n_fail++; $display("FAIL b2b_fc_before: got %0d expected %0d", frame_count, exp_fc); end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    exp_fc = FC_EN ? exp_fc + 16'd1 : 16'd0;
    tick();
    e = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL b2b_origin: got %h expected %h", obs, e); end
    n_checks++;
    if (frame_count !== exp_fc) begin n_fail++; $display("FAIL b2b_fc_after: got %0d expected %0d", frame_count, exp_fc); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    logic [23:0] e;
    while (!(DrawX === 10'd100 && DrawY === 10'd2) && n < 3000) begin tick(); n++; end
    n_checks++;
    if (n >= 3000) begin n_fail++; $display("FAIL rmid_reach: got timeout expected (100,2)"); end
    #2 reset = 1'b1;
    #1;
    e = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL rmid_async: got %h expected %h", obs, e); end
    exp_fc = 16'd0;
    n_checks++;
    if (frame_count !== exp_fc) begin n_fail++; $display("FAIL rmid_fc: got %0d expected 0", frame_count); end
    @(negedge clk);
    reset = 1'b0;
    tick();
    e = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL rmid_restart: got %h expected %h", obs, e); end
    tick();
    e = {10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL rmid_resume: got %h expected %h", obs, e); end
  endtask

  initial begin
    exp_fc = 16'd0;
    test_reset();
    test_line();
    test_frame();
    test_restart_mid();
    test_restart_hold();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
